// File: rtl/lc3_dbg_pkg.sv
// Shared types for the LC-3 debug dump paths: widths, dump FSM states and the
// streamed tx word layout.
package lc3_dbg_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        SUM,
        DONE
    } dump_state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              sum;
    } tx_word_t;

endpackage

// File: rtl/regdump_tx_buf.sv
// Output holding register with a valid/ready handshake; width-generic so the
// memory dump path can reuse it with its own word layout.
module regdump_tx_buf #(
    parameter int W = 21
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_word,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] word,
    output logic         fire
);

    assign fire = valid && ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid <= 1'b0;
            // NOTE: the word register is reset too, because the observable tx
            // fields must read zero after reset, not just tx_valid.
            word  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= load_word;
        end else if (fire) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Walks R0..R(NUM_REGS-1) through the SR1 select and streams each value out.
// Define REGDUMP_CHECKSUM_EN to append a modulo-2^DATA_W checksum word.
module regfile_dump_ctrl #(
    parameter int DATA_W   = lc3_dbg_pkg::DATA_W,
    parameter int NUM_REGS = lc3_dbg_pkg::NUM_REGS,
    parameter int IDX_W    = lc3_dbg_pkg::IDX_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic [IDX_W-1:0]  rf_sel,
    input  logic [DATA_W-1:0] rf_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [IDX_W-1:0]  tx_idx,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic              tx_sum,
    output logic              busy,
    output logic              done
);
    import lc3_dbg_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              sum;
    } word_t;

    dump_state_t      state, state_next;
    logic [IDX_W-1:0] idx;
    logic             grant_wait;
    logic             load, fire, valid;
    word_t            load_word, word;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = READ;
            READ: if (!grant_wait) state_next = SEND;
`ifdef REGDUMP_CHECKSUM_EN
            SEND: if (fire) state_next = (idx == LAST_IDX) ? SUM : READ;
            SUM:  if (fire) state_next = DONE;
`else
            SEND: if (fire) state_next = (idx == LAST_IDX) ? DONE : READ;
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The first read after start waits one cycle so the external SR1 mux,
    // which switches on busy, has settled before rf_data is captured.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx        <= '0;
            grant_wait <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx        <= '0;
                    grant_wait <= 1'b1;
                end
                READ: grant_wait <= 1'b0;
                SEND: if (fire && idx != LAST_IDX) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (Reset)                            csum <= '0;
        else if (state == IDLE && start)      csum <= '0;
        else if (state == READ && !grant_wait) csum <= csum + rf_data;
    end
`endif

    // NOTE: every comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        load      = 1'b0;
        load_word = '0;
        case (state)
            READ: if (!grant_wait) begin
                load           = 1'b1;
                load_word.idx  = idx;
                load_word.data = rf_data;
`ifdef REGDUMP_CHECKSUM_EN
                load_word.last = 1'b0;
`else
                load_word.last = (idx == LAST_IDX);
`endif
            end
`ifdef REGDUMP_CHECKSUM_EN
            SUM: if (!valid) begin
                load           = 1'b1;
                load_word.data = csum;
                load_word.last = 1'b1;
                load_word.sum  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign rf_sel = idx;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    regdump_tx_buf #(
        .W($bits(word_t))
    ) u_tx_buf (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (load),
        .load_word (load_word),
        .ready     (tx_ready),
        .valid     (valid),
        .word      (word),
        .fire      (fire)
    );

    assign tx_valid = valid;
    assign tx_idx   = word.idx;
    assign tx_data  = word.data;
    assign tx_last  = word.last;
    assign tx_sum   = word.sum;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: cycle table for a plain dump,
// directed corner sequences, and random dumps against a word-list model.
module tb_regfile_dump_ctrl;
    import lc3_dbg_pkg::*;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif
    localparam int NW   = NUM_REGS + CSUM;
    localparam int NCYC = 2 * NW + 2;

    logic              Clk, Reset, start, tx_ready;
    logic [IDX_W-1:0]  rf_sel, tx_idx;
    logic [DATA_W-1:0] rf_data, tx_data;
    logic              tx_valid, tx_last, tx_sum, busy, done;

    logic [DATA_W-1:0] rf [NUM_REGS];
    assign rf_data = rf[rf_sel];

    int       n_cmp = 0;
    int       n_fail = 0;
    int       done_cnt = 0;
    int       base;
    tx_word_t got_q[$];
    tx_word_t exp_q[$];

    typedef struct {
        logic              ready;
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              sum;
        logic              busy;
        logic              done;
    } vec_t;
    vec_t tbl [NCYC];

    regfile_dump_ctrl dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (start),
        .rf_sel   (rf_sel),
        .rf_data  (rf_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_idx   (tx_idx),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_sum   (tx_sum),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Handshakes and done pulses are observed mid-cycle, away from the edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (tx_valid && tx_ready)
                got_q.push_back(tx_word_t'({tx_idx, tx_data, tx_last, tx_sum}));
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int c;
        c = 0;
        while (!done && c < bound) begin
            tick();
            c++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic wait_word(input string name, input logic [IDX_W-1:0] want, input int bound);
        int c;
        c = 0;
        while (!(tx_valid && tx_idx == want) && c < bound) begin
            tick();
            c++;
        end
        check({name, "_word_seen"}, 32'(tx_valid && tx_idx == want), 32'd1);
    endtask

    // Model: a dump is the register list in order, then the optional checksum.
    task automatic build_expected();
        logic [DATA_W-1:0] s;
        s = '0;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back(tx_word_t'{idx: IDX_W'(i), data: rf[i],
                                       last: (i == NUM_REGS - 1) && (CSUM == 0), sum: 1'b0});
            s = s + rf[i];
        end
        if (CSUM != 0)
            exp_q.push_back(tx_word_t'{idx: '0, data: s, last: 1'b1, sum: 1'b1});
    endtask

    task automatic compare_dump(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_idle(input string name);
        check(name, 32'({tx_valid, tx_idx, tx_data, tx_last, tx_sum, busy, done, rf_sel}), 32'd0);
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i + 1);
    endtask

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        tx_ready = 1'b0;
        preload_ramp();
        tick();
        tick();
        Reset = 1'b0;
        check_idle("reset_state");

        // Cycle table: entry n is the state sampled just after edge En.
        for (int n = 1; n <= NCYC; n++) begin
            int   k;
            vec_t v;
            k       = (n - 2) / 2;
            v.ready = 1'b1;
            v.valid = (n >= 2) && (n <= 2 * NW) && (n % 2 == 0);
            v.idx   = (k < NUM_REGS) ? IDX_W'(k) : '0;
            v.data  = (k < NUM_REGS) ? DATA_W'(k + 1) : DATA_W'(NUM_REGS * (NUM_REGS + 1) / 2);
            v.last  = ((k == NUM_REGS - 1) && (CSUM == 0)) || (k == NUM_REGS);
            v.sum   = (k == NUM_REGS);
            v.busy  = (n <= 2 * NW + 1);
            v.done  = (n == 2 * NW + 1);
            tbl[n-1] = v;
        end

        // Basic dump against the cycle table.
        build_expected();
        got_q.delete();
        base = done_cnt;
        tx_ready = 1'b1;
        pulse_start();
        for (int n = 1; n <= NCYC; n++) begin
            tx_ready = tbl[n-1].ready;
            tick();
            check($sformatf("basic_n%0d_ctl", n), 32'({busy, done, tx_valid}),
                  32'({tbl[n-1].busy, tbl[n-1].done, tbl[n-1].valid}));
            if (tbl[n-1].valid)
                check($sformatf("basic_n%0d_word", n), 32'({tx_idx, tx_data, tx_last, tx_sum}),
                      32'({tbl[n-1].idx, tbl[n-1].data, tbl[n-1].last, tbl[n-1].sum}));
        end
        tick();
        compare_dump("basic");
        check("basic_done_count", 32'(done_cnt - base), 32'd1);

        // Back-pressure on the idx 3 word.
        preload_ramp();
        rf[3] = 16'hBEEF;
        build_expected();
        got_q.delete();
        base = done_cnt;
        tx_ready = 1'b1;
        pulse_start();
        wait_word("bp", 3'd3, 40);
        tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), 32'({tx_valid, tx_idx, tx_data}),
                  32'({1'b1, 3'd3, 16'hBEEF}));
        end
        tx_ready = 1'b1;
        wait_done("bp", 40);
        tick();
        tick();
        compare_dump("bp");
        check("bp_done_count", 32'(done_cnt - base), 32'd1);

        // Start while busy, start in DONE, start in the following IDLE cycle.
        preload_ramp();
        build_expected();
        got_q.delete();
        base = done_cnt;
        pulse_start();
        repeat (5) tick();
        pulse_start();
        wait_done("busy", 40);
        start = 1'b1;
        tick();
        check("start_in_done_ignored", 32'(busy), 32'd0);
        tick();
        check("start_after_done_accepted", 32'(busy), 32'd1);
        start = 1'b0;
        compare_dump("busy_first");
        check("busy_done_count1", 32'(done_cnt - base), 32'd1);
        got_q.delete();
        wait_done("busy_second", 40);
        tick();
        tick();
        compare_dump("busy_second");
        check("busy_done_count2", 32'(done_cnt - base), 32'd2);

        // Reset while the idx 4 word waits in SEND.
        preload_ramp();
        got_q.delete();
        base = done_cnt;
        tx_ready = 1'b1;
        pulse_start();
        wait_word("rst", 3'd4, 40);
        tx_ready = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_idle("rst_mid_outputs");
        check("rst_words_before", 32'(got_q.size()), 32'd4);
        tx_ready = 1'b1;
        repeat (25) tick();
        check("rst_no_done", 32'(done_cnt - base), 32'd0);
        check("rst_no_more_words", 32'(got_q.size()), 32'd4);
        check_idle("rst_still_idle");

        // R6 rewritten while idx 2 is in flight; the dump must show the new value.
        preload_ramp();
        rf[6] = 16'h2222;
        build_expected();
        rf[6] = 16'h1111;
        got_q.delete();
        base = done_cnt;
        pulse_start();
        wait_word("cw", 3'd2, 40);
        rf[6] = 16'h2222;
        wait_done("cw", 40);
        tick();
        tick();
        compare_dump("cw");

`ifdef REGDUMP_CHECKSUM_EN
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 16'hFFFF;
        build_expected();
        got_q.delete();
        pulse_start();
        wait_done("cs", 60);
        tick();
        tick();
        compare_dump("cs");
        if (got_q.size() == 9) begin
            check("cs_sum_word", 32'({got_q[8].data, got_q[8].sum, got_q[8].last}),
                  32'({16'hFFF8, 1'b1, 1'b1}));
            check("cs_r7_not_last", 32'(got_q[7].last), 32'd0);
        end
`endif

        // Random dumps with random back-pressure and start noise while busy.
        for (int it = 0; it < 6; it++) begin
            int c;
            for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'($urandom);
            build_expected();
            got_q.delete();
            base = done_cnt;
            pulse_start();
            c = 0;
            while (!done && c < 400) begin
                tx_ready = ($urandom_range(0, 9) < 6);
                start    = ($urandom_range(0, 4) == 0);
                tick();
                c++;
            end
            start = 1'b0;
            check($sformatf("rand%0d_done_seen", it), 32'(done), 32'd1);
            tx_ready = 1'b1;
            tick();
            tick();
            compare_dump($sformatf("rand%0d", it));
            check($sformatf("rand%0d_done_count", it), 32'(done_cnt - base), 32'd1);
            check($sformatf("rand%0d_idle", it), 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
